// File: rtl/OoO_pkg.sv
// Shared types for the out-of-order core: functional-unit opcodes and the
// CSR functional-unit FSM encoding.
package OoO_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CSR_ADDR_W = 12;

    typedef enum logic [2:0] {
        FU_NOP,
        CSR_READ,
        CSR_WRITE,
        CSR_SET,
        CSR_CLEAR
    } fu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StWaitHead,
        StExec,
        StWb
    } csr_fu_state_e;

endpackage

// File: rtl/csr_fu.sv
// CSR functional unit: holds one CSR/ecall/mret instruction until it is the ROB
// head, performs the register-file access for one cycle, then writes back.
module csr_fu
    import OoO_pkg::*;
#(
    parameter int unsigned ROB_IDX_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,

    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  fu_op_e                issue_op,
    input  logic [CSR_ADDR_W-1:0] issue_csr_addr,
    input  logic [XLEN-1:0]       issue_wdata,
    input  logic [XLEN-1:0]       issue_pc,
    input  logic [ROB_IDX_W-1:0]  issue_rob_idx,
    input  logic                  issue_is_ecall,
    input  logic                  issue_is_mret,

    input  logic                  rob_head_valid,
    input  logic [ROB_IDX_W-1:0]  rob_head_idx,

    output fu_op_e                csr_op,
    output logic [CSR_ADDR_W-1:0] csr_addr,
    output logic [XLEN-1:0]       csr_wdata,
    output logic [XLEN-1:0]       csr_pc,
    output logic                  ecall,
    output logic                  mret,
    input  logic [XLEN-1:0]       csr_rdata,
    input  logic [XLEN-1:0]       mtvec_addr,
    input  logic [XLEN-1:0]       mepc_addr,

    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [ROB_IDX_W-1:0]  wb_rob_idx,
    output logic [XLEN-1:0]       wb_data,

    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc
);

    csr_fu_state_e         state_q;
    fu_op_e                op_q;
    logic [CSR_ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]       wdata_q;
    logic [XLEN-1:0]       pc_q;
    logic [ROB_IDX_W-1:0]  rob_q;
    logic                  is_ecall_q;
    logic                  is_mret_q;
    fu_op_e                csr_op_q;
    logic                  ecall_q;
    logic                  mret_q;
    logic                  wb_valid_q;
    logic [XLEN-1:0]       wb_data_q;
    logic [XLEN-1:0]       redirect_pc_q;

    logic                  is_sys;
    logic                  head_hit;

    assign is_sys   = is_ecall_q | is_mret_q;
    assign head_hit = rob_head_valid && (rob_head_idx == rob_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            op_q          <= FU_NOP;
            addr_q        <= '0;
            wdata_q       <= '0;
            pc_q          <= '0;
            rob_q         <= '0;
            is_ecall_q    <= 1'b0;
            is_mret_q     <= 1'b0;
            csr_op_q      <= FU_NOP;
            ecall_q       <= 1'b0;
            mret_q        <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= '0;
            redirect_pc_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (issue_valid && !flush) begin
                        op_q       <= issue_op;
                        addr_q     <= issue_csr_addr;
                        wdata_q    <= issue_wdata;
                        pc_q       <= issue_pc;
                        rob_q      <= issue_rob_idx;
                        is_ecall_q <= issue_is_ecall;
                        is_mret_q  <= issue_is_mret;
                        state_q    <= StWaitHead;
                    end
                end
                StWaitHead: begin
                    // A squash beats a simultaneous head match: nothing has touched the CSRs yet.
                    if (flush) begin
                        state_q <= StIdle;
                    end else if (head_hit) begin
                        csr_op_q <= is_sys ? FU_NOP : op_q;
                        ecall_q  <= is_ecall_q;
                        mret_q   <= is_mret_q;
                        state_q  <= StExec;
                    end
                end
                StExec: begin
                    csr_op_q   <= FU_NOP;
                    ecall_q    <= 1'b0;
                    mret_q     <= 1'b0;
                    // csr_rdata is the pre-write value since the write lands on this edge.
                    wb_data_q  <= is_sys ? '0 : csr_rdata;
                    if (is_ecall_q) begin
                        redirect_pc_q <= mtvec_addr;
                    end else if (is_mret_q) begin
                        redirect_pc_q <= mepc_addr;
                    end
                    wb_valid_q <= 1'b1;
                    state_q    <= StWb;
                end
                StWb: begin
                    if (wb_ready) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
            endcase
        end
    end

    // Gated by reset so the unit never advertises readiness while held in reset.
    assign issue_ready    = reset && (state_q == StIdle);
    assign csr_op         = csr_op_q;
    assign csr_addr       = addr_q;
    assign csr_wdata      = wdata_q;
    assign csr_pc         = pc_q;
    assign ecall          = ecall_q;
    assign mret           = mret_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rob_idx     = rob_q;
    assign wb_data        = wb_data_q;
    assign redirect_valid = wb_valid_q && wb_ready && is_sys;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_fu.sv
// Directed bench for csr_fu with a small CSR file environment and a
// transaction-level model checked against the DUT every cycle.
module tb_csr_fu;
    import OoO_pkg::*;

    localparam logic [11:0] MSTATUS  = 12'h300;
    localparam logic [11:0] MTVEC    = 12'h305;
    localparam logic [11:0] MSCRATCH = 12'h340;
    localparam logic [11:0] MEPC     = 12'h341;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    fu_op_e      issue_op;
    logic [11:0] issue_csr_addr;
    logic [31:0] issue_wdata;
    logic [31:0] issue_pc;
    logic [3:0]  issue_rob_idx;
    logic        issue_is_ecall;
    logic        issue_is_mret;
    logic        rob_head_valid;
    logic [3:0]  rob_head_idx;
    fu_op_e      csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_pc;
    logic        ecall;
    logic        mret;
    logic [31:0] csr_rdata;
    logic [31:0] mtvec_addr;
    logic [31:0] mepc_addr;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_rob_idx;
    logic [31:0] wb_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_bad = 0;

    csr_fu #(.ROB_IDX_W(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_op       (issue_op),
        .issue_csr_addr (issue_csr_addr),
        .issue_wdata    (issue_wdata),
        .issue_pc       (issue_pc),
        .issue_rob_idx  (issue_rob_idx),
        .issue_is_ecall (issue_is_ecall),
        .issue_is_mret  (issue_is_mret),
        .rob_head_valid (rob_head_valid),
        .rob_head_idx   (rob_head_idx),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_pc         (csr_pc),
        .ecall          (ecall),
        .mret           (mret),
        .csr_rdata      (csr_rdata),
        .mtvec_addr     (mtvec_addr),
        .mepc_addr      (mepc_addr),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_rob_idx     (wb_rob_idx),
        .wb_data        (wb_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // CSR register-file environment (stands in for csr_regfile).
    logic [31:0] mem [0:4095];
    assign csr_rdata  = mem[csr_addr];
    assign mtvec_addr = mem[MTVEC];
    assign mepc_addr  = mem[MEPC];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem[MSTATUS]  <= 32'h0;
            mem[MTVEC]    <= 32'h8000_0000;
            mem[MEPC]     <= 32'h0;
            mem[MSCRATCH] <= 32'h0000_00F0;
        end else begin
            case (csr_op)
                CSR_WRITE: mem[csr_addr] <= csr_wdata;
                CSR_SET:   mem[csr_addr] <= mem[csr_addr] | csr_wdata;
                CSR_CLEAR: mem[csr_addr] <= mem[csr_addr] & ~csr_wdata;
                default:   ;
            endcase
            if (ecall) mem[MEPC] <= csr_pc;
        end
    end

    // Transaction model: 0 free, 1 waiting for head, 2 accessing CSRs, 3 writing back.
    int          m_stage;
    fu_op_e      m_op;
    logic [11:0] m_addr;
    logic [31:0] m_wdata, m_pc, m_wb, m_rpc;
    logic [3:0]  m_rob;
    logic        m_ec, m_mr;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_stage <= 0;
        end else if (m_stage == 0) begin
            if (issue_valid && !flush) begin
                m_stage <= 1;
                m_op    <= issue_op;
                m_addr  <= issue_csr_addr;
                m_wdata <= issue_wdata;
                m_pc    <= issue_pc;
                m_rob   <= issue_rob_idx;
                m_ec    <= issue_is_ecall;
                m_mr    <= issue_is_mret;
            end
        end else if (m_stage == 1) begin
            if (flush) m_stage <= 0;
            else if (rob_head_valid && rob_head_idx == m_rob) m_stage <= 2;
        end else if (m_stage == 2) begin
            m_stage <= 3;
            m_wb    <= (m_ec || m_mr) ? 32'h0 : mem[m_addr];
            m_rpc   <= m_ec ? mem[MTVEC] : mem[MEPC];
        end else if (wb_ready) begin
            m_stage <= 0;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("rst_issue_ready", 32'(issue_ready), 32'h0);
            check("rst_wb_valid", 32'(wb_valid), 32'h0);
            check("rst_redirect_valid", 32'(redirect_valid), 32'h0);
            check("rst_csr_op", 32'(csr_op), 32'(FU_NOP));
            check("rst_ecall_mret", 32'({ecall, mret}), 32'h0);
        end else begin
            check("issue_ready", 32'(issue_ready), 32'(m_stage == 0));
            check("csr_op", 32'(csr_op),
                  (m_stage == 2 && !(m_ec || m_mr)) ? 32'(m_op) : 32'(FU_NOP));
            check("ecall", 32'(ecall), 32'(m_stage == 2 && m_ec));
            check("mret", 32'(mret), 32'(m_stage == 2 && m_mr));
            if (m_stage == 2) begin
                check("csr_addr", 32'(csr_addr), 32'(m_addr));
                check("csr_wdata", csr_wdata, m_wdata);
                check("csr_pc", csr_pc, m_pc);
            end
            check("wb_valid", 32'(wb_valid), 32'(m_stage == 3));
            if (m_stage == 3) begin
                check("wb_rob_idx", 32'(wb_rob_idx), 32'(m_rob));
                check("wb_data", wb_data, m_wb);
            end
            check("redirect_valid", 32'(redirect_valid),
                  32'(m_stage == 3 && wb_ready && (m_ec || m_mr)));
            if (m_stage == 3 && wb_ready && (m_ec || m_mr))
                check("redirect_pc", redirect_pc, m_rpc);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_txn(input fu_op_e op, input logic [11:0] addr, input logic [31:0] wd,
                           input logic [31:0] pc, input logic [3:0] rob, input logic ec,
                           input logic mr, input int head_delay, input int wb_delay,
                           output logic [31:0] got_data, output logic got_redir,
                           output logic [31:0] got_pc);
        int k;
        issue_valid = 1'b1; issue_op = op; issue_csr_addr = addr; issue_wdata = wd;
        issue_pc = pc; issue_rob_idx = rob; issue_is_ecall = ec; issue_is_mret = mr;
        step();
        issue_valid = 1'b0;
        repeat (head_delay) step();
        rob_head_valid = 1'b1; rob_head_idx = rob;
        step();
        rob_head_valid = 1'b0;
        k = 0;
        while (wb_valid !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check("wb_wait_bound", 32'(k < 20), 32'h1);
        repeat (wb_delay) step();
        wb_ready = 1'b1;
        #1;
        got_data  = wb_data;
        got_redir = redirect_valid;
        got_pc    = redirect_pc;
        step();
        wb_ready = 1'b0;
    endtask

    logic [31:0] d, p;
    logic        r;

    initial begin
        reset = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_op = FU_NOP;
        issue_csr_addr = '0; issue_wdata = '0; issue_pc = '0; issue_rob_idx = '0;
        issue_is_ecall = 1'b0; issue_is_mret = 1'b0; rob_head_valid = 1'b0;
        rob_head_idx = '0; wb_ready = 1'b0;
        repeat (2) step();
        check("reset_issue_ready", 32'(issue_ready), 32'h0);
        reset = 1'b1;
        #1;
        check("post_reset_ready", 32'(issue_ready), 32'h1);
        step();

        // CSRRW mtvec
        run_txn(CSR_WRITE, MTVEC, 32'h8000_0100, 32'h8000_0010, 4'd3, 1'b0, 1'b0, 2, 0, d, r, p);
        check("csrrw_old_mtvec", d, 32'h8000_0000);
        check("csrrw_no_redirect", 32'(r), 32'h0);
        check("mtvec_written", mem[MTVEC], 32'h8000_0100);

        // ecall
        run_txn(FU_NOP, 12'h0, 32'h0, 32'h8000_0040, 4'd4, 1'b1, 1'b0, 1, 0, d, r, p);
        check("ecall_redirect", 32'(r), 32'h1);
        check("ecall_redirect_pc", p, 32'h8000_0100);
        check("ecall_wb_data", d, 32'h0);
        check("ecall_mepc", mem[MEPC], 32'h8000_0040);

        // set mepc, then mret with a stalled writeback
        run_txn(CSR_WRITE, MEPC, 32'h8000_0044, 32'h8000_0048, 4'd5, 1'b0, 1'b0, 0, 0, d, r, p);
        check("csrrw_old_mepc", d, 32'h8000_0040);
        run_txn(FU_NOP, 12'h0, 32'h0, 32'h8000_004C, 4'd6, 1'b0, 1'b1, 3, 5, d, r, p);
        check("mret_redirect", 32'(r), 32'h1);
        check("mret_redirect_pc", p, 32'h8000_0044);
        check("mret_wb_data", d, 32'h0);

        // set / clear on mscratch
        run_txn(CSR_SET, MSCRATCH, 32'h0000_000F, 32'h8000_0050, 4'd7, 1'b0, 1'b0, 0, 1, d, r, p);
        check("csrrs_old", d, 32'h0000_00F0);
        check("csrrs_new", mem[MSCRATCH], 32'h0000_00FF);
        run_txn(CSR_CLEAR, MSCRATCH, 32'h0000_003C, 32'h8000_0054, 4'd8, 1'b0, 1'b0, 4, 0, d, r, p);
        check("csrrc_old", d, 32'h0000_00FF);
        check("csrrc_new", mem[MSCRATCH], 32'h0000_00C3);

        // flush while waiting for head, with a coincident head match
        issue_valid = 1'b1; issue_op = CSR_WRITE; issue_csr_addr = MSCRATCH;
        issue_wdata = 32'hDEAD_BEEF; issue_rob_idx = 4'd9; issue_is_ecall = 1'b0;
        issue_is_mret = 1'b0;
        step();
        issue_valid = 1'b0;
        flush = 1'b1; rob_head_valid = 1'b1; rob_head_idx = 4'd9;
        step();
        flush = 1'b0;
        check("flush_wait_ready", 32'(issue_ready), 32'h1);
        repeat (3) step();
        rob_head_valid = 1'b0;
        check("flush_wait_no_write", mem[MSCRATCH], 32'h0000_00C3);

        // flush together with issue in idle
        issue_valid = 1'b1; flush = 1'b1; issue_rob_idx = 4'd10;
        step();
        issue_valid = 1'b0; flush = 1'b0;
        check("flush_idle_ready", 32'(issue_ready), 32'h1);
        rob_head_valid = 1'b1; rob_head_idx = 4'd10;
        repeat (3) step();
        rob_head_valid = 1'b0;
        check("flush_idle_no_write", mem[MSCRATCH], 32'h0000_00C3);

        // reset in the middle of writeback of an ecall
        issue_valid = 1'b1; issue_op = FU_NOP; issue_pc = 32'h8000_0080;
        issue_rob_idx = 4'd11; issue_is_ecall = 1'b1;
        step();
        issue_valid = 1'b0; issue_is_ecall = 1'b0;
        rob_head_valid = 1'b1; rob_head_idx = 4'd11;
        step();
        rob_head_valid = 1'b0;
        step();
        check("pre_reset_wb_valid", 32'(wb_valid), 32'h1);
        step();
        wb_ready = 1'b1;
        reset = 1'b0;
        #1;
        check("async_wb_valid", 32'(wb_valid), 32'h0);
        check("async_redirect_valid", 32'(redirect_valid), 32'h0);
        check("async_redirect_pc", redirect_pc, 32'h0);
        check("async_wb_data", wb_data, 32'h0);
        check("async_issue_ready", 32'(issue_ready), 32'h0);
        wb_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        check("release_ready", 32'(issue_ready), 32'h1);
        check("release_wb_rob_idx", 32'(wb_rob_idx), 32'h0);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
